// File: rtl/ripple_carry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_pkg
// Description : Shared definitions for the ripple_carry_12 adder slice.
//               RC_WIDTH_DEFAULT - default operand/sum width (12)
//               rc_word_t        - operand word at the default width
// Revision    : 1.0 - initial release
// ============================================================================
package ripple_carry_pkg;

    localparam int RC_WIDTH_DEFAULT = 12;

    typedef logic [RC_WIDTH_DEFAULT-1:0] rc_word_t;

endpackage : ripple_carry_pkg
`default_nettype wire

// File: rtl/ripple_carry_12_full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : One-bit full adder, purely combinational. This is the unit
//               cell of the ripple chain in ripple_carry_12.
// Ports       : a, b  - addend bits
//               ci    - carry in
//               s     - sum bit    (a ^ b ^ ci)
//               co    - carry out  (majority of a, b, ci)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/ripple_carry_12.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_12
// Description : WIDTH-bit ripple-carry adder built from a chain of
//               full_adder_cell instances, followed by a one-cycle
//               registered output stage. {cout, s} = a + b + cin.
// Parameters  : WIDTH - operand and sum width in bits (>= 1), default 12
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous reset, active high
//               in_valid  - a, b, cin valid this cycle
//               a, b      - unsigned operands [WIDTH-1:0]
//               cin       - carry into bit 0
//               s         - registered sum [WIDTH-1:0]
//               cout      - registered carry out of the MSB
//               out_valid - s/cout hold a fresh result this cycle
//               ovf       - registered two's-complement overflow
//                           (only when RIPPLE_CARRY_OVERFLOW_EN is defined)
// Config      : RIPPLE_CARRY_OVERFLOW_EN - adds the ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_12
    import ripple_carry_pkg::*;
#(
    parameter int WIDTH = RC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef RIPPLE_CARRY_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // ------------------------------------------------------------------
    // Combinational ripple chain: carry[i] feeds cell i, carry[WIDTH] is
    // the final carry out.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (s_d[i]),
            .co (carry[i+1])
        );
    end

    assign cout_d = carry[WIDTH];

    // ------------------------------------------------------------------
    // Output register. Data flops only load under in_valid, so operands
    // (including X) presented while in_valid=0 never reach the outputs.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
            end
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

`ifdef RIPPLE_CARRY_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : ripple_carry_12
`default_nettype wire

// File: tb/tb_ripple_carry_12.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_carry_12
// Description : Self-checking bench for ripple_carry_12. Directed boundary
//               vectors plus randomized traffic compared against an
//               arithmetic reference model (a + b + cin with held outputs).
// Config      : RIPPLE_CARRY_OVERFLOW_EN - also checks the ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_carry_12;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         out_valid;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
    logic         ovf;
`endif

    ripple_carry_12 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
`ifdef RIPPLE_CARRY_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the outputs should show right now.
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_v;
    logic         exp_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".s"},         32'(s),         32'(exp_s));
        chk({tag, ".cout"},      32'(cout),      32'(exp_c));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
`ifdef RIPPLE_CARRY_OVERFLOW_EN
        chk({tag, ".ovf"},       32'(ovf),       32'(exp_o));
`endif
    endtask

    // Drive one cycle of stimulus at the falling edge, then check the
    // registered result just after the following rising edge.
    task automatic cycle(input string tag, input logic v, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic tc);
        int unsigned total;
        int signed   sa, sb, ssum;
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb;
        cin      = tc;
        @(posedge clk);
        #1;
        if (v) begin
            total = int'(ta) + int'(tb) + int'(tc);
            exp_s = total[W-1:0];
            exp_c = total[W];
            // Signed overflow: true signed sum falls outside W-bit range.
            sa    = int'($signed(ta));
            sb    = int'($signed(tb));
            ssum  = sa + sb + int'(tc);
            exp_o = (ssum > (2 ** (W - 1)) - 1) || (ssum < -(2 ** (W - 1)));
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        check_outputs(tag);
    endtask

    initial begin
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        rst      = 1'b1;
        exp_s    = '0;
        exp_c    = 1'b0;
        exp_v    = 1'b0;
        exp_o    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, issued back to back.
        cycle("fc0+03f+0", 1'b1, 12'hFC0, 12'h03F, 1'b0);
        cycle("fc0+03f+1", 1'b1, 12'hFC0, 12'h03F, 1'b1);
        cycle("0e5+02b+1", 1'b1, 12'h0E5, 12'h02B, 1'b1);
        cycle("fff+fff+1", 1'b1, 12'hFFF, 12'hFFF, 1'b1);
        cycle("fff+000+1", 1'b1, 12'hFFF, 12'h000, 1'b1);
        cycle("7ff+001+0", 1'b1, 12'h7FF, 12'h001, 1'b0);
        cycle("800+800+0", 1'b1, 12'h800, 12'h800, 1'b0);

        // Valid ends: out_valid drops, data holds despite new operands.
        cycle("idle1", 1'b0, 12'h123, 12'h456, 1'b1);
        cycle("idle2", 1'b0, 12'hABC, 12'hDEF, 1'b0);

        // Asynchronous reset between edges with a result held.
        cycle("preload", 1'b1, 12'h5A5, 12'h0F0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 12'h111;
        b        = 12'h222;
        #2;
        rst = 1'b1;
        #1;
        exp_s = '0;
        exp_c = 1'b0;
        exp_v = 1'b0;
        exp_o = 1'b0;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        cycle("after_rst_idle", 1'b0, 12'h000, 12'h000, 1'b0);
        cycle("001+001+0", 1'b1, 12'h001, 12'h001, 1'b0);

        // Randomized traffic with random valid gaps.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(3) != 0),
                  W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ripple_carry_12
`default_nettype wire
